// File: rtl/invaders_pkg.sv
// Shared constants and encodings for the invader fleet.
// Optional speed-up feature is enabled by defining INVADER_SPEEDUP_EN.
package invaders_pkg;

  localparam int COLS       = 20;
  localparam int SHIP_ROW   = 14;
  localparam int STEP_TICKS = 8;
  localparam int BX_W       = 5;
  localparam int BY_W       = 4;

  localparam logic [COLS-1:0] INIT_PATTERN = 20'b00101010101010101010;

  typedef enum logic [1:0] {
    ST_MARCH     = 2'd0,
    ST_WAVE_DONE = 2'd1,
    ST_LANDED    = 2'd2
  } fleet_state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } fleet_dir_e;

endpackage

// File: rtl/invader_step_timer.sv
// Counts enable ticks and emits a one-cycle step strobe each march period.
// With INVADER_SPEEDUP_EN defined the period shrinks as the fleet thins out.
module invader_step_timer
  import invaders_pkg::*;
#(
  parameter int COLS       = invaders_pkg::COLS,
  parameter int STEP_TICKS = invaders_pkg::STEP_TICKS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            restart,
  input  logic            run,
  input  logic            enable,
`ifdef INVADER_SPEEDUP_EN
  input  logic [COLS-1:0] alive,
`endif
  output logic            step
);

  localparam int CNT_W      = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int HALF_TICKS = (STEP_TICKS / 2 < 1) ? 1 : STEP_TICKS / 2;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   period;
  logic             last_tick;

`ifdef INVADER_SPEEDUP_EN
  localparam int POP_W = $clog2(COLS + 1);
  logic [POP_W-1:0] alive_cnt;

  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < COLS; i++) begin
      alive_cnt = alive_cnt + POP_W'(alive[i]);
    end
  end

  always_comb begin
    period = (CNT_W+1)'(STEP_TICKS);
    if (alive_cnt < POP_W'(3)) begin
      period = (CNT_W+1)'(1);
    end else if (alive_cnt < POP_W'(10)) begin
      period = (CNT_W+1)'(HALF_TICKS);
    end
  end
`else
  assign period = (CNT_W+1)'(STEP_TICKS);
`endif

  // ">=" rather than "==": the period can drop below the running count mid-step
  assign last_tick = (({1'b0, cnt_q}) + (CNT_W+1)'(1)) >= period;
  assign step      = run && enable && last_tick;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run && enable) begin
      cnt_d = last_tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/invader_fleet.sv
// Invader fleet: march/bounce/descend, bullet hit detection, wave and landing FSM.
// Define INVADER_SPEEDUP_EN to make the march speed depend on the live invader count.
module invader_fleet
  import invaders_pkg::*;
#(
  parameter int              COLS         = invaders_pkg::COLS,
  parameter int              STEP_TICKS   = invaders_pkg::STEP_TICKS,
  parameter int              SHIP_ROW     = invaders_pkg::SHIP_ROW,
  parameter logic [COLS-1:0] INIT_PATTERN = invaders_pkg::INIT_PATTERN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [BX_W-1:0] bullet_x,
  input  logic [BY_W-1:0] bullet_y,
  input  logic            bullet_active,
  output logic [COLS-1:0] inv_array,
  output logic [BY_W-1:0] inv_line,
  output logic            hit,
  output logic            wave_cleared,
  output logic            landed
);

  localparam logic [BY_W-1:0] LAND_ROW = BY_W'(SHIP_ROW);

  fleet_state_e    state_q, state_d;
  fleet_dir_e      dir_q, dir_d;
  logic [COLS-1:0] arr_q, arr_d;
  logic [BY_W-1:0] line_q, line_d;
  logic            hit_q, hit_d;
  logic            wave_q, wave_d;
  logic            landed_q, landed_d;

  logic [COLS-1:0] sel_mask;
  logic [COLS-1:0] hit_vec;
  logic [COLS-1:0] arr_hit;
  logic [BY_W-1:0] line_inc;
  logic            hit_now;
  logic            step;

  // Columns at or beyond COLS match no bit, so out-of-range bullets never hit
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_sel
      assign sel_mask[gi] = (bullet_x == BX_W'(gi));
    end
  endgenerate

  assign hit_vec  = arr_q & sel_mask;
  assign hit_now  = (state_q == ST_MARCH) && bullet_active &&
                    (bullet_y == line_q) && (|hit_vec);
  assign arr_hit  = hit_now ? (arr_q & ~hit_vec) : arr_q;
  assign line_inc = (line_q >= LAND_ROW) ? line_q : line_q + BY_W'(1);

  invader_step_timer #(
    .COLS       (COLS),
    .STEP_TICKS (STEP_TICKS)
  ) u_step_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (clear || (state_q == ST_WAVE_DONE)),
    .run     (state_q == ST_MARCH),
    .enable  (enable),
`ifdef INVADER_SPEEDUP_EN
    .alive   (arr_q),
`endif
    .step    (step)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    arr_d    = arr_q;
    line_d   = line_q;
    hit_d    = 1'b0;
    wave_d   = 1'b0;
    landed_d = landed_q;
    case (state_q)
      ST_MARCH: begin
        hit_d = hit_now;
        arr_d = arr_hit;
        // The shift works on the post-hit array so a destroyed invader never returns
        if (step) begin
          if (dir_q == DIR_RIGHT) begin
            if (arr_hit[COLS-1]) begin
              line_d = line_inc;
              dir_d  = DIR_LEFT;
            end else begin
              arr_d = {arr_hit[COLS-2:0], 1'b0};
            end
          end else begin
            if (arr_hit[0]) begin
              line_d = line_inc;
              dir_d  = DIR_RIGHT;
            end else begin
              arr_d = {1'b0, arr_hit[COLS-1:1]};
            end
          end
        end
        // Clearing the wave takes priority over landing in the same cycle
        if (arr_d == '0) begin
          state_d = ST_WAVE_DONE;
          wave_d  = 1'b1;
        end else if (line_d >= LAND_ROW) begin
          state_d  = ST_LANDED;
          landed_d = 1'b1;
        end
      end
      ST_WAVE_DONE: begin
        arr_d   = INIT_PATTERN;
        line_d  = '0;
        dir_d   = DIR_RIGHT;
        state_d = ST_MARCH;
      end
      ST_LANDED: begin
        state_d = ST_LANDED;
      end
      default: begin
        state_d = ST_MARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q  <= ST_MARCH;
      dir_q    <= DIR_RIGHT;
      arr_q    <= INIT_PATTERN;
      line_q   <= '0;
      hit_q    <= 1'b0;
      wave_q   <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      arr_q    <= arr_d;
      line_q   <= line_d;
      hit_q    <= hit_d;
      wave_q   <= wave_d;
      landed_q <= landed_d;
    end
  end

  assign inv_array    = arr_q;
  assign inv_line     = line_q;
  assign hit          = hit_q;
  assign wave_cleared = wave_q;
  assign landed       = landed_q;

endmodule

// File: tb/tb_invader_fleet.sv
// Directed self-checking bench for invader_fleet (default parameters).
// Expectations follow INVADER_SPEEDUP_EN when it is defined for the build.
module tb_invader_fleet;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        enable;
  logic [4:0]  bullet_x;
  logic [3:0]  bullet_y;
  logic        bullet_active;
  logic [19:0] inv_array;
  logic [3:0]  inv_line;
  logic        hit;
  logic        wave_cleared;
  logic        landed;

  int checks    = 0;
  int failures  = 0;
  int hit_count = 0;

  localparam logic [19:0] INIT = 20'b00101010101010101010;
`ifdef INVADER_SPEEDUP_EN
  localparam int FULL_P = 4;
`else
  localparam int FULL_P = 8;
`endif

  always #5 clk = ~clk;

  invader_fleet dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .enable        (enable),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .inv_array     (inv_array),
    .inv_line      (inv_line),
    .hit           (hit),
    .wave_cleared  (wave_cleared),
    .landed        (landed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=0x%0h", tag, got);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (hit === 1'b1) hit_count++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; enable = 1'b0; bullet_active = 1'b0;
    cycle(2);
    reset = 1'b0;
    hit_count = 0;
  endtask

  task automatic ticks(input int n);
    enable = 1'b1;
    cycle(n);
    enable = 1'b0;
  endtask

  task automatic shoot(input int x, input int y);
    bullet_active = 1'b1; bullet_x = 5'(x); bullet_y = 4'(y);
    cycle(1);
    bullet_active = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; enable = 1'b0;
    bullet_active = 1'b0; bullet_x = '0; bullet_y = '0;

    // reset state
    do_reset();
    check("rst_array", inv_array, INIT);
    check("rst_line", inv_line, 0);
    check("rst_hit", hit, 0);
    check("rst_wave", wave_cleared, 0);
    check("rst_landed", landed, 0);

    // first march step
    ticks(FULL_P - 1);
    check("pre_step_array", inv_array, INIT);
    ticks(1);
    check("step1_array", inv_array, 20'h55554);
    check("step1_line", inv_line, 0);

    // single hit with a lingering bullet
    do_reset();
    bullet_active = 1'b1; bullet_x = 5'd1; bullet_y = 4'd0;
    cycle(1);
    check("hit_pulse", hit, 1);
    check("hit_bit_cleared", inv_array, 20'h2AAA8);
    cycle(1);
    check("hit_one_cycle", hit, 0);
    cycle(3);
    check("hit_linger_count", hit_count, 1);
    bullet_active = 1'b0;

    // boundary misses: out-of-range column, wrong line
    shoot(20, 0);
    check("x20_no_hit", hit, 0);
    shoot(31, 0);
    check("x31_array", inv_array, 20'h2AAA8);
    shoot(3, 1);
    check("wrong_line_no_hit", hit, 0);

    // reset coinciding with a hit discards it
    bullet_active = 1'b1; bullet_x = 5'd3; bullet_y = 4'd0; reset = 1'b1;
    cycle(1);
    bullet_active = 1'b0; reset = 1'b0;
    check("rst_mid_hit_array", inv_array, INIT);
    cycle(1);
    check("rst_mid_hit_pulse", hit, 0);

    // hit and step in the same cycle
    do_reset();
    ticks(FULL_P - 1);
    enable = 1'b1; bullet_active = 1'b1; bullet_x = 5'd17; bullet_y = 4'd0;
    cycle(1);
    enable = 1'b0; bullet_active = 1'b0;
    check("hit_step_pulse", hit, 1);
    check("hit_step_array", inv_array, 20'h15554);

    // edge bounce and descent
    do_reset();
    ticks(2 * FULL_P);
    check("edge_array", inv_array, 20'hAAAA8);
    ticks(FULL_P);
    check("bounce_array", inv_array, 20'hAAAA8);
    check("bounce_line", inv_line, 1);
    ticks(FULL_P);
    check("left_shift_array", inv_array, 20'h55554);

    // clear the whole wave
    do_reset();
    for (int b = 1; b < 17; b += 2) shoot(b, 0);
    shoot(17, 0);
    check("wave_pulse", wave_cleared, 1);
    check("wave_empty", inv_array, 0);
    check("wave_hit_count", hit_count, 9);
    cycle(1);
    check("wave_pulse_end", wave_cleared, 0);
    check("wave_reload", inv_array, INIT);
    check("wave_line", inv_line, 0);
    ticks(FULL_P);
    check("wave_march", inv_array, 20'h55554);

    // landing and freeze
    do_reset();
    ticks(54 * FULL_P);
    check("line13", inv_line, 13);
    check("not_landed", landed, 0);
    ticks(FULL_P);
    check("line14", inv_line, 14);
    check("landed", landed, 1);
    check("landed_array", inv_array, 20'h15555);
    bullet_active = 1'b1; bullet_x = 5'd0; bullet_y = 4'd14;
    ticks(2 * FULL_P);
    bullet_active = 1'b0;
    check("frozen_array", inv_array, 20'h15555);
    check("frozen_line", inv_line, 14);
    check("frozen_no_hit", hit_count, 0);
    clear = 1'b1;
    cycle(1);
    clear = 1'b0;
    check("clear_landed", landed, 0);
    check("clear_array", inv_array, INIT);
    check("clear_line", inv_line, 0);

    // two survivors: march speed
    do_reset();
    for (int b = 1; b < 15; b += 2) shoot(b, 0);
    check("two_left", inv_array, 20'h28000);
`ifdef INVADER_SPEEDUP_EN
    ticks(1);
    check("fast_step1", inv_array, 20'h50000);
    ticks(1);
    check("fast_step2", inv_array, 20'hA0000);
    ticks(1);
    check("fast_bounce_line", inv_line, 1);
`else
    ticks(7);
    check("slow_no_step", inv_array, 20'h28000);
    ticks(1);
    check("slow_step", inv_array, 20'h50000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/invader_fleet.md
INVADER_FLEET -- requirements
Module: invader_fleet

Interface
REQ-001 Parameter COLS, default 20: number of invader columns; bit i of the array is column i.
REQ-002 Parameter STEP_TICKS, default 8: number of enable ticks per march step.
REQ-003 Parameter SHIP_ROW, default 14: line index at which the fleet has landed.
REQ-004 Parameter INIT_PATTERN, default 20'b00101010101010101010: array contents loaded at wave start.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clear  in  1  synchronous game restart; same effect as reset.
REQ-008 enable  in  1  single-cycle game tick; gates all march timing.
REQ-009 bullet_x  in  5  column of the player bullet.
REQ-010 bullet_y  in  4  line of the player bullet.
REQ-011 bullet_active  in  1  the player bullet is flying.
REQ-012 inv_array  out  COLS  alive mask of invaders.
REQ-013 inv_line  out  4  current fleet line, 0 = top.
REQ-014 hit  out  1  one-cycle pulse when a bullet destroys an invader.
REQ-015 wave_cleared  out  1  one-cycle pulse when the last invader dies.
REQ-016 landed  out  1  level; high while the fleet has reached SHIP_ROW.

Function
REQ-017 FSM states: MARCH, WAVE_DONE, LANDED.
REQ-018 MARCH -> WAVE_DONE when inv_array becomes zero.
REQ-019 MARCH -> LANDED when inv_line reaches SHIP_ROW.
REQ-020 WAVE_DONE lasts exactly one cycle; it reloads INIT_PATTERN, sets inv_line=0 and dir=right, then returns to MARCH.
REQ-021 LANDED holds every output frozen until reset or clear.
REQ-022 Hit detection, every cycle in MARCH, independent of enable:
- condition: bullet_active=1, bullet_y==inv_line, bullet_x<COLS and inv_array[bullet_x]=1;
- hit is registered and asserts on the next cycle;
- the addressed bit is cleared on that same edge.
REQ-023 bullet_x>=COLS never hits.
REQ-024 A bit already cleared cannot re-hit, so a bullet lingering for several cycles produces at most one hit.
REQ-025 Step timer:
- a counter increments only on enable;
- a step occurs on the enable tick at which the counter reaches period-1; the counter then returns to 0.
REQ-026 Step, dir=right:
- if bit COLS-1 is set: inv_line+1, dir flips to left, array unchanged;
- else: array shifts one bit toward the higher index (bit 0 filled with 0).
REQ-027 Step, dir=left: mirror of REQ-026, using bit 0 and a shift toward the lower index.
REQ-028 Hit and step in the same cycle: the hit clear is applied first, then the shift; the hit invader never reappears.
REQ-029 inv_line saturates at SHIP_ROW; it never wraps.
REQ-030 wave_cleared pulses on the cycle FSM enters WAVE_DONE.
REQ-031 The last invader being hit wins over a step that would land in the same cycle: the result is WAVE_DONE, not LANDED.

Reset
REQ-032 On reset or clear:
- inv_array=INIT_PATTERN, inv_line=0, dir=right, step counter=0, state=MARCH;
- hit=0, wave_cleared=0, landed=0.
REQ-033 Reset or clear mid-step or mid-hit discards the pending step or hit; no pulse is emitted afterward.

Configuration
REQ-034 Macro INVADER_SPEEDUP_EN defined: the step period depends on the live invader count:
- count>=10: period = STEP_TICKS;
- count 3..9: period = STEP_TICKS/2 (minimum 1);
- count 1..2: period = 1.
REQ-035 Macro INVADER_SPEEDUP_EN undefined: period = STEP_TICKS always, and no popcount logic is synthesized.

Structure
REQ-036 Shared package invaders_pkg holds COLS, SHIP_ROW, INIT_PATTERN, the state encoding, and the bullet coordinate widths (5/4).
REQ-037 One sub-module, invader_step_timer, holds the tick counter and period selection (including the speed-up) and outputs a one-cycle step strobe.

Verification
REQ-038 Reset, then 8 enable ticks with no bullet -> inv_array=20'b01010101010101010100, inv_line=0.
REQ-039 bullet_active=1, bullet_x=1, bullet_y=0 right after reset -> hit for exactly one cycle, bit1 cleared, no second hit while the bullet is held.
REQ-040 March the fleet until bit19 is set, then one more step -> inv_line=1, dir=left, array unchanged; the following step shifts toward bit0.
REQ-041 Hit all 9 invaders -> wave_cleared for one cycle, then inv_array=INIT_PATTERN and inv_line=0.
REQ-042 Run with no hits until inv_line=14 -> landed=1 and outputs frozen; clear -> landed=0 and pattern reloaded.
REQ-043 With INVADER_SPEEDUP_EN, leave 2 invaders alive -> one step per enable tick; without the macro -> one step per 8 ticks.
